l10_unscrambler: RTL and testbench
==================================

# l10_unscrambler

Receive-side inverse of the team's 4-bit phase scrambler. That scrambler cycles a 2-bit phase 0,1,2,3 per word, sending the inverted word on phase 0 and the word rotated left by 1/2/3 on phases 1/2/3. This block tracks the same phase, undoes the transform and recovers the original word. It sits between the scrambled link and downstream logic, with valid/ready flow control on both sides and a sync input to align its phase.

## Interface
Parameters:
- COUNT_W, 8, width of the decoded-word counter.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately.
- in_valid  input  1  in_data/in_sync are valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  4  scrambled word.
- in_sync  input  1  qualified by in_valid; marks the word as phase 0.
- out_valid  output  1  out_data holds a decoded word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  4  recovered word.
- locked  output  1  phase alignment established.
- phase  output  2  phase that will be applied to the next accepted word.
- word_count  output  COUNT_W  number of decoded words delivered; wraps.

## Operation
- Accept is in_valid && in_ready. Deliver is out_valid && out_ready.
- in_ready = !out_valid || out_ready: a single output register, so a word can be accepted in the same cycle the held word is delivered.
- Decode uses the effective phase p. On an accept with in_sync=1, p=0. Otherwise p = phase.
  - p=0: out = ~in_data.
  - p=1: rotate right 1, i.e. out = {in[0],in[3],in[2],in[1]}.
  - p=2: rotate right 2, i.e. out = {in[1],in[0],in[3],in[2]}.
  - p=3: rotate right 3, i.e. out = {in[2],in[1],in[0],in[3]}.
- Phase update: on every accept, phase <= p+1 (mod 4, so 3 wraps to 0). phase holds when nothing is accepted.
- State machine, UNLOCKED / LOCKED:
  - UNLOCKED after reset.
  - UNLOCKED: non-sync accepted words are consumed and discarded. They produce no output and phase does not advance.
  - UNLOCKED, accept with in_sync=1: go to LOCKED, decode that word with p=0, load it into the output register, phase <= 1.
  - LOCKED: every accepted word is decoded and loaded. A sync word re-aligns the phase (p=0) and the block stays LOCKED.
  - There is no LOCKED→UNLOCKED transition except reset.
- locked = 1 exactly in LOCKED.
- Output register:
  - Loaded on an accept that produces a word; out_valid <= 1.
  - On a deliver with no new load, out_valid <= 0.
  - On a simultaneous deliver and load, out_valid stays 1 and out_data takes the new word.
- word_count increments by 1 on each deliver and wraps from 2^COUNT_W-1 to 0.

## Timing
- Reset values: out_valid=0, out_data=4'b0000, locked=0, phase=2'b00, word_count=0. in_ready=1 while reset is deasserted and out_valid=0.
- Latency is 1 cycle: a word accepted at edge N has out_valid=1 with its decoded data after edge N.
- Throughput is one word per cycle when out_ready is held high.
- When out_ready=0 with out_valid=1: in_ready=0, out_data is stable, and phase does not advance.
- Reset asserted mid-stream: all state clears asynchronously and any held output word is lost. After release the block is UNLOCKED and needs a new sync.
- in_sync with in_valid=0 is ignored.

## Test plan
- Reset, then feed sync word 4'b0111 followed by 4'b0001, 4'b0010, 4'b0100 with out_ready=1 -> out_data 4'b1000 on four consecutive cycles; phase sequence 1,2,3,0; word_count=4.
- After reset, feed 3 non-sync words, then sync word 4'b0101 -> no out_valid for the first 3; locked rises with the sync accept; out_data=4'b1010.
- While locked with phase=2, accept a sync word 4'b1100 -> out_data=4'b0011 (inverted, not rotated); phase=1 afterwards.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, phase frozen. On release, the next word is decoded with the correct phase and none are lost or duplicated.
- Stream 2^COUNT_W+2 words with COUNT_W=8 -> word_count wraps 255→0 and reads 2 at the end.
- Assert reset mid-stream with out_valid=1 -> out_valid, locked, phase, word_count all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/l10_unscrambler.sv
// Receive-side inverse of the 4-bit phase scrambler: tracks the per-word phase,
// undoes invert/rotate and presents recovered words through a one-entry output register.
module l10_unscrambler #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_data,
    input  logic               in_sync,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_data,
    output logic               locked,
    output logic [1:0]         phase,
    output logic [COUNT_W-1:0] word_count
);

    localparam int unsigned WORD_W  = 4;
    localparam int unsigned PHASE_W = 2;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 deliver;
    logic                 load;
    logic [PHASE_W-1:0]   eff_phase;
    logic [WORD_W-1:0]    decoded;
    logic                 out_valid_nxt;
    logic [WORD_W-1:0]    out_data_nxt;
    logic [PHASE_W-1:0]   phase_nxt;
    logic [COUNT_W-1:0]   word_count_nxt;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign eff_phase = in_sync ? PHASE_W'(0) : phase;
    assign locked    = (state == ST_LOCKED);

    // Inverse transform: invert on phase 0, rotate right by phase otherwise.
    always_comb begin
        decoded = '0;
        case (eff_phase)
            2'd0:    decoded = ~in_data;
            2'd1:    decoded = {in_data[0],   in_data[3:1]};
            2'd2:    decoded = {in_data[1:0], in_data[3:2]};
            default: decoded = {in_data[2:0], in_data[3]};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_UNLOCKED: if (accept && in_sync) state_nxt = ST_LOCKED;
            default:     state_nxt = ST_LOCKED;
        endcase
    end

    // Unlocked non-sync words are swallowed: no load, no phase advance.
    always_comb begin
        load           = accept && (state == ST_LOCKED || in_sync);
        out_valid_nxt  = out_valid;
        out_data_nxt   = out_data;
        phase_nxt      = phase;
        word_count_nxt = word_count;
        if (deliver) begin
            out_valid_nxt  = 1'b0;
            word_count_nxt = word_count + COUNT_W'(1);
        end
        if (load) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = decoded;
            phase_nxt     = eff_phase + PHASE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            phase      <= '0;
            word_count <= '0;
        end else begin
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
            phase      <= phase_nxt;
            word_count <= word_count_nxt;
        end
    end

endmodule

// File: tb/tb_l10_unscrambler.sv
// Bench for l10_unscrambler: explicit vector table, hand-built corner sequences,
// and random traffic against an arithmetic reference model.
module tb_l10_unscrambler;

    localparam int unsigned COUNT_W = 8;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_data;
    logic               in_sync;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_data;
    logic               locked;
    logic [1:0]         phase;
    logic [COUNT_W-1:0] word_count;

    l10_unscrambler #(.COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sync    (in_sync),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .locked     (locked),
        .phase      (phase),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state
    bit m_valid;
    int m_data;
    bit m_locked;
    int m_phase;
    int m_count;

    typedef struct {
        bit       rst;
        bit       v;
        bit [3:0] d;
        bit       s;
        bit       r;
        bit       ev;
        bit [3:0] ed;
        bit       el;
        bit [1:0] ep;
        int       ec;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_decode(input int x, input int p);
        if (p == 0) return (~x) & 15;
        return ((x >> p) | (x << (4 - p))) & 15;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_locked = 0; m_phase = 0; m_count = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, int'(out_valid), int'(m_valid));
        check({tag, ".out_data"}, int'(out_data), m_data);
        check({tag, ".locked"}, int'(locked), int'(m_locked));
        check({tag, ".phase"}, int'(phase), m_phase);
        check({tag, ".word_count"}, int'(word_count), m_count);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 0; in_data = 0; in_sync = 0; out_ready = 0;
        model_reset();
        @(negedge clk);
        check_model("reset");
        check("reset.in_ready", int'(in_ready), 1);
        reset = 1'b1;
    endtask

    // One clock: drive at negedge, check in_ready, update model at posedge, compare.
    task automatic step(input bit v, input bit [3:0] d, input bit s, input bit r,
                        input string tag);
        bit acc, del, produce;
        int p;
        @(negedge clk);
        in_valid = v; in_data = d; in_sync = s; out_ready = r;
        #1;
        check({tag, ".in_ready"}, int'(in_ready), int'(!m_valid || r));
        acc     = v && (!m_valid || r);
        del     = m_valid && r;
        p       = s ? 0 : m_phase;
        produce = acc && (m_locked || s);
        @(posedge clk);
        #1;
        if (del) m_count = (m_count + 1) % (1 << COUNT_W);
        if (produce) begin
            m_data   = ref_decode(int'(d), p);
            m_phase  = (p + 1) % 4;
            m_locked = 1;
            m_valid  = 1;
        end else if (del) begin
            m_valid = 0;
        end
        check_model(tag);
    endtask

    function automatic vec_t mk(input bit rst, input bit v, input bit [3:0] d, input bit s,
                                input bit r, input bit ev, input bit [3:0] ed, input bit el,
                                input bit [1:0] ep, input int ec);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.s = s; t.r = r;
        t.ev = ev; t.ed = ed; t.el = el; t.ep = ep; t.ec = ec;
        return t;
    endfunction

    initial begin
        bit [3:0] held;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        in_valid = 0; in_data = 0; in_sync = 0; out_ready = 0;
        model_reset();

        // Sync then three words that all decode to 1000
        tbl.push_back(mk(1, 1, 4'b0111, 1, 1, 1, 4'b1000, 1, 2'd1, 0));
        tbl.push_back(mk(0, 1, 4'b0001, 0, 1, 1, 4'b1000, 1, 2'd2, 1));
        tbl.push_back(mk(0, 1, 4'b0010, 0, 1, 1, 4'b1000, 1, 2'd3, 2));
        tbl.push_back(mk(0, 1, 4'b0100, 0, 1, 1, 4'b1000, 1, 2'd0, 3));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 4'b1000, 1, 2'd0, 4));
        // Unlocked words are discarded until the sync
        tbl.push_back(mk(1, 1, 4'b0011, 0, 1, 0, 4'b0000, 0, 2'd0, 0));
        tbl.push_back(mk(0, 1, 4'b1001, 0, 1, 0, 4'b0000, 0, 2'd0, 0));
        tbl.push_back(mk(0, 1, 4'b1110, 0, 1, 0, 4'b0000, 0, 2'd0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 1, 1, 0, 4'b0000, 0, 2'd0, 0));
        tbl.push_back(mk(0, 1, 4'b0101, 1, 1, 1, 4'b1010, 1, 2'd1, 0));
        // Resync at phase 2 inverts instead of rotating
        tbl.push_back(mk(0, 1, 4'b0110, 0, 1, 1, 4'b0011, 1, 2'd2, 1));
        tbl.push_back(mk(0, 1, 4'b1100, 1, 1, 1, 4'b0011, 1, 2'd1, 2));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 4'b0011, 1, 2'd1, 3));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.exp_valid", i), int'(out_valid), int'(tbl[i].ev));
            check($sformatf("tbl%0d.exp_data", i), int'(out_data), int'(tbl[i].ed));
            check($sformatf("tbl%0d.exp_locked", i), int'(locked), int'(tbl[i].el));
            check($sformatf("tbl%0d.exp_phase", i), int'(phase), int'(tbl[i].ep));
            check($sformatf("tbl%0d.exp_count", i), int'(word_count), tbl[i].ec);
        end

        // Backpressure: output held, phase frozen, nothing lost on release
        do_reset();
        step(1, 4'b1010, 1, 1, "stall.sync");
        step(1, 4'b0011, 0, 1, "stall.load");
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            step(1, 4'($urandom_range(0, 15)), 0, 0, "stall.hold");
            check("stall.in_ready", int'(in_ready), 0);
            check("stall.data_stable", int'(out_data), int'(held));
            check("stall.phase_frozen", int'(phase), 2);
        end
        step(1, 4'b0001, 0, 1, "stall.release");
        check("stall.release_data", int'(out_data), 4'b0100);
        check("stall.release_count", int'(word_count), 2);
        step(0, 4'b0000, 0, 1, "stall.drain");
        check("stall.drain_count", int'(word_count), 3);

        // Counter wrap: 258 delivered words end at 2
        do_reset();
        step(1, 4'($urandom_range(0, 15)), 1, 1, "wrap.sync");
        for (int i = 0; i < (1 << COUNT_W) + 1; i++)
            step(1, 4'($urandom_range(0, 15)), 0, 1, "wrap");
        step(0, 4'b0000, 0, 1, "wrap.drain");
        check("wrap.count", int'(word_count), 2);

        // Asynchronous reset with a word held
        do_reset();
        step(1, 4'b0110, 1, 0, "areset.load");
        step(1, 4'b0110, 0, 1, "areset.next");
        @(negedge clk);
        out_ready = 0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("areset.out_valid", int'(out_valid), 0);
        check("areset.locked", int'(locked), 0);
        check("areset.phase", int'(phase), 0);
        check("areset.word_count", int'(word_count), 0);
        check("areset.out_data", int'(out_data), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1, 4'b0101, 0, 1, "areset.unlocked");
        check("areset.needs_sync", int'(out_valid), 0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 3) != 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
